// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the load/save memory responder.
// The handshake state encoding matches the one used by the load/save handler FSMs.
package data_mem_responder_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_MEMORY_SIZE = 64;

  // 4-phase handshake states shared with the requester side
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } hs_state_e;

endpackage : data_mem_responder_pkg

// File: rtl/data_mem_responder_port_fsm.sv
// mem_port_fsm: generic responder-side 4-phase req/ack FSM.
//   clk, rst   : clock, asynchronous active-high reset
//   req        : requester strobe, held until ack seen
//   done       : access completes on this edge (only meaningful in BUSY)
//   state      : registered handshake state
//   ack        : registered acknowledge, high while in ACK
//   capture_c  : combinational strobe, latch request payload on this edge
module mem_port_fsm
  import data_mem_responder_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      req,
  input  logic      done,
  output hs_state_e state,
  output logic      ack,
  output logic      capture_c
);

  hs_state_e state_q, state_d;
  logic      ack_q, ack_d;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
    end
  end

  // Next state; a request held in ACK is not re-accepted until it falls
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d   = ST_BUSY;
          capture_c = 1'b1;
        end
      end
      ST_BUSY: if (done) state_d = ST_ACK;
      ST_ACK:  if (!req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ack_d = (state_d == ST_ACK);
  end

  assign state = state_q;
  assign ack   = ack_q;

endmodule : mem_port_fsm

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the load/save memory protocol.
// One read and one write channel, each a 4-phase req/ack handshake, over a
// DATA_WIDTH x MEMORY_SIZE array. Same-address collisions: the write wins.
// Build option: RD_BYPASS_EN -- a colliding read completes with the write and
// returns the new write data; otherwise it waits one cycle and reads the array.
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset (clears array)
//   rd_req, rd_addr             : read request / address
//   rd_ack, rd_data             : read acknowledge / result (held until next read)
//   wr_req, wr_addr, wr_data    : write request / address / data
//   wr_ack                      : write committed
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned MEMORY_SIZE = DEF_MEMORY_SIZE,
  localparam int unsigned ADDR_W     = $clog2(MEMORY_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack
);

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [MEMORY_SIZE];
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  hs_state_e rd_state, wr_state;
  logic      rd_cap_c, wr_cap_c;
  logic      rd_done_c, wr_done_c;
  logic      collide_c, wr_commit_c;

  // Non-power-of-2 arrays leave a hole at the top of the address space
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < MEMORY_SIZE);
  endfunction

  mem_port_fsm u_rd_fsm (
    .clk       (clk),
    .rst       (reset),
    .req       (rd_req),
    .done      (rd_done_c),
    .state     (rd_state),
    .ack       (rd_ack),
    .capture_c (rd_cap_c)
  );

  mem_port_fsm u_wr_fsm (
    .clk       (clk),
    .rst       (reset),
    .req       (wr_req),
    .done      (wr_done_c),
    .state     (wr_state),
    .ack       (wr_ack),
    .capture_c (wr_cap_c)
  );

  // Collision detection and access completion
  always_comb begin
    collide_c   = (rd_state == ST_BUSY) && (wr_state == ST_BUSY) && (rd_addr_q == wr_addr_q);
    wr_done_c   = (wr_state == ST_BUSY);
    wr_commit_c = wr_done_c && addr_ok(wr_addr_q);
`ifdef RD_BYPASS_EN
    rd_done_c   = (rd_state == ST_BUSY);
`else
    // Colliding read stalls so it sees the committed write next cycle
    rd_done_c   = (rd_state == ST_BUSY) && !collide_c;
`endif
  end

  // Payload latches, array update and read result
  always_comb begin
    rd_addr_d = rd_cap_c ? rd_addr : rd_addr_q;
    wr_addr_d = wr_cap_c ? wr_addr : wr_addr_q;
    wr_data_d = wr_cap_c ? wr_data : wr_data_q;

    mem_d = mem_q;
    if (wr_commit_c) mem_d[wr_addr_q] = wr_data_q;

    rd_data_d = rd_data_q;
    if (rd_done_c) begin
      if (!addr_ok(rd_addr_q))  rd_data_d = '0;
      else if (collide_c)       rd_data_d = wr_data_q;
      else                      rd_data_d = mem_q[rd_addr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MEMORY_SIZE); i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios then random
// read/write pairs with random start skew, checked against a word-array model.
module tb_data_mem_responder;

  localparam int unsigned DW = 8;
  localparam int unsigned MS = 64;
  localparam int unsigned AW = 6;
`ifdef RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req, wr_req;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_ack, wr_ack;

  logic [DW-1:0] ref_mem [MS];
  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(DW), .MEMORY_SIZE(MS)) dut (
    .clk     (clk),
    .reset   (reset),
    .rd_req  (rd_req),
    .rd_addr (rd_addr),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .wr_req  (wr_req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_ack  (wr_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One read and/or one write, each starting at its own cycle offset. The
  // payload is disturbed after acceptance when scramble is set.
  task automatic run_pair(input bit en_rd, input bit en_wr, input int rd_dly, input int wr_dly,
                          input logic [AW-1:0] ra, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input int hold, input bit scramble);
    int rd_seen = -1;
    int wr_seen = -1;
    int rd_exp, wr_exp;
    bit coll;
    logic [DW-1:0] exp_rd;
    coll   = en_rd && en_wr && (ra == wa) && (rd_dly == wr_dly);
    // Read sees the write if the write was accepted no later than the read
    exp_rd = (en_wr && (ra == wa) && (wr_dly <= rd_dly)) ? wd : ref_mem[ra];
    rd_exp = en_rd ? (rd_dly + 1 + ((coll && !BYP) ? 1 : 0)) : -1;
    wr_exp = en_wr ? (wr_dly + 1) : -1;
    for (int c = 0; c < 4 + hold; c++) begin
      @(negedge clk);
      if (scramble && rd_req) rd_addr = ra + AW'(1);
      if (scramble && wr_req) begin
        wr_addr = wa + AW'(1);
        wr_data = ~wd;
      end
      if (en_rd && c == rd_dly) begin rd_req = 1'b1; rd_addr = ra; end
      if (en_wr && c == wr_dly) begin wr_req = 1'b1; wr_addr = wa; wr_data = wd; end
      @(posedge clk); #1;
      if (rd_ack && rd_seen < 0) rd_seen = c;
      if (wr_ack && wr_seen < 0) wr_seen = c;
    end
    chk("rd_ack_cycle", 32'(rd_seen), 32'(rd_exp));
    chk("wr_ack_cycle", 32'(wr_seen), 32'(wr_exp));
    chk("rd_ack_held", 32'(rd_ack), 32'(en_rd));
    chk("wr_ack_held", 32'(wr_ack), 32'(en_wr));
    if (en_rd) chk("rd_data", 32'(rd_data), 32'(exp_rd));
    if (en_wr) ref_mem[wa] = wd;
    @(negedge clk);
    rd_req = 1'b0;
    wr_req = 1'b0;
    @(posedge clk); #1;
    chk("rd_ack_fall", 32'(rd_ack), 32'(0));
    chk("wr_ack_fall", 32'(wr_ack), 32'(0));
    if (en_rd) chk("rd_data_hold", 32'(rd_data), 32'(exp_rd));
  endtask

  initial begin
    bit er, ew;
    for (int i = 0; i < int'(MS); i++) ref_mem[i] = '0;
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_ack", 32'(rd_ack), 32'(0));
    chk("reset_wr_ack", 32'(wr_ack), 32'(0));
    chk("reset_rd_data", 32'(rd_data), 32'(0));
    @(negedge clk); reset = 1'b0;

    // Reset mid-transaction clears acks, data and array at once
    run_pair(1'b0, 1'b1, 0, 0, 6'd0, 6'd5, 8'h77, 0, 1'b0);
    @(negedge clk);
    rd_req = 1'b1; rd_addr = 6'd5;
    wr_req = 1'b1; wr_addr = 6'd9; wr_data = 8'h99;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_rd_data", 32'(rd_data), 32'(8'h77));
    #1 reset = 1'b1;
    #1;
    chk("async_rd_ack", 32'(rd_ack), 32'(0));
    chk("async_wr_ack", 32'(wr_ack), 32'(0));
    chk("async_rd_data", 32'(rd_data), 32'(0));
    rd_req = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < int'(MS); i++) ref_mem[i] = '0;
    @(negedge clk); reset = 1'b0;
    run_pair(1'b1, 1'b0, 0, 0, 6'd5, 6'd0, 8'h00, 0, 1'b0);

    // Write then read back
    run_pair(1'b0, 1'b1, 0, 0, 6'd0, 6'd3, 8'hA5, 0, 1'b0);
    run_pair(1'b1, 1'b0, 0, 0, 6'd3, 6'd0, 8'h00, 0, 1'b0);
    // Concurrent, different addresses
    run_pair(1'b0, 1'b1, 0, 0, 6'd0, 6'd20, 8'h11, 0, 1'b0);
    run_pair(1'b1, 1'b1, 0, 0, 6'd20, 6'd10, 8'h3C, 0, 1'b0);
    // Same-address collision
    run_pair(1'b0, 1'b1, 0, 0, 6'd0, 6'd7, 8'h01, 0, 1'b0);
    run_pair(1'b1, 1'b1, 0, 0, 6'd7, 6'd7, 8'hFE, 0, 1'b0);
    // Request held long after ack, then immediate re-request
    run_pair(1'b1, 1'b0, 0, 0, 6'd10, 6'd0, 8'h00, 5, 1'b0);
    run_pair(1'b1, 1'b0, 0, 0, 6'd3, 6'd0, 8'h00, 0, 1'b0);
    // Address changes while busy: latched address wins
    run_pair(1'b0, 1'b1, 0, 0, 6'd0, 6'd4, 8'h44, 0, 1'b0);
    run_pair(1'b1, 1'b0, 0, 0, 6'd3, 6'd0, 8'h00, 0, 1'b1);

    // Random pairs over a narrow address range so collisions are common
    for (int n = 0; n < 200; n++) begin
      er = 1'(($urandom & 32'd3) != 0);
      ew = 1'(($urandom & 32'd3) != 0);
      if (!er && !ew) ew = 1'b1;
      run_pair(er, ew, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
               DW'($urandom), int'($urandom_range(0, 2)), 1'($urandom & 32'd1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_data_mem_responder
